// File: rtl/ram_tap_line_buffer_pkg.sv
// Shared helpers for the RAM-backed multi-tap line buffer.
package ram_tap_lb_pkg;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Depth fields are one bit wider than the RAM address so MAX_DEPTH itself fits.
  function automatic int depth_w(input int max_depth);
    return clog2(max_depth) + 1;
  endfunction

  localparam int DEFAULT_MAX_DEPTH = 64;
  localparam int DEPTH_W           = depth_w(DEFAULT_MAX_DEPTH);

  // Map a requested depth onto the legal range 1..max_depth.
  function automatic int clamp_depth(input int cfg, input int max_depth);
    if (cfg <= 0) begin
      return 1;
    end else if (cfg > max_depth) begin
      return max_depth;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/ram_tap_line_buffer_if.sv
// Control/data bundle of the line buffer: the master drives samples and
// configuration, the slave (the buffer) returns the taps and their valid flags.
interface ram_tap_line_buffer_if
  import ram_tap_lb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_TAPS = 3,
  parameter int D_W      = DEPTH_W
);
  logic                      flush;
  logic [D_W-1:0]            cfg_depth;
  logic                      shift_en;
  logic [WIDTH-1:0]          shift_in;
  logic [NUM_TAPS*WIDTH-1:0] tap_out;
  logic [NUM_TAPS-1:0]       tap_valid;

  modport master (
    output flush, cfg_depth, shift_en, shift_in,
    input  tap_out, tap_valid
  );

  modport slave (
    input  flush, cfg_depth, shift_en, shift_in,
    output tap_out, tap_valid
  );
endinterface

// File: rtl/ram_tap_line_buffer_segment.sv
// One delay segment: MAX_DEPTH x WIDTH RAM. The read returns the word stored
// before this cycle's write, so the caller sees the old sample it is replacing.
module ram_tap_lb_segment
  import ram_tap_lb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 64,
  parameter int ADDR_W    = clog2(MAX_DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [MAX_DEPTH];

  // Write port; the array is deliberately never cleared.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Old contents are visible until the edge, giving read-before-write.
  assign rdata = mem[addr];
endmodule

// File: rtl/ram_tap_line_buffer.sv
// Multi-tap RAM shift register: tap k delays the input by (k+1)*depth accepted
// shifts. Segments share one pointer; each pops its oldest word into the next.
module ram_tap_line_buffer
  import ram_tap_lb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 64,
  parameter int NUM_TAPS  = 3
) (
  input logic                   clock,
  input logic                   reset,
  ram_tap_line_buffer_if.slave  bus
);
  localparam int D_W    = depth_w(MAX_DEPTH);
  localparam int PTR_W  = clog2(MAX_DEPTH);
  localparam int FILL_W = clog2(NUM_TAPS * MAX_DEPTH + 2);

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [D_W-1:0]            depth_q, depth_d;
  logic [NUM_TAPS*WIDTH-1:0] tap_q, tap_d;
  logic [NUM_TAPS-1:0]       valid_q, valid_d;

  logic [D_W-1:0]    cfg_clamped;
  logic              accept;
  logic [FILL_W-1:0] fill_inc;
  logic [FILL_W-1:0] fill_cap;
  logic [NUM_TAPS-1:0] valid_hit;
  logic [WIDTH-1:0]  seg_rdata [NUM_TAPS];
  logic [WIDTH-1:0]  seg_wdata [NUM_TAPS];
  logic [FILL_W-1:0] thresh    [NUM_TAPS];

  assign cfg_clamped = D_W'(clamp_depth(int'(bus.cfg_depth), MAX_DEPTH));
  // A shift coinciding with reset or flush is dropped, RAM included.
  assign accept   = bus.shift_en & ~reset & ~bus.flush;
  assign fill_inc = fill_q + FILL_W'(1);
  assign fill_cap = FILL_W'(NUM_TAPS) * FILL_W'(depth_q);

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_seg
    if (gi == 0) begin : g_head
      assign seg_wdata[gi] = bus.shift_in;
    end else begin : g_chain
      assign seg_wdata[gi] = seg_rdata[gi-1];
    end

    // Tap gi turns valid once the post-shift fill exceeds its total delay.
    assign thresh[gi]    = FILL_W'(gi + 1) * FILL_W'(depth_q);
    assign valid_hit[gi] = (fill_inc > thresh[gi]);

    ram_tap_lb_segment #(
      .WIDTH     (WIDTH),
      .MAX_DEPTH (MAX_DEPTH)
    ) u_seg (
      .clock (clock),
      .we    (accept),
      .addr  (ptr_q),
      .wdata (seg_wdata[gi]),
      .rdata (seg_rdata[gi])
    );
  end

  // Next-state: flush restarts the stream, a shift advances it, idle holds.
  always_comb begin
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    depth_d = depth_q;
    tap_d   = tap_q;
    valid_d = valid_q;
    if (bus.flush) begin
      ptr_d   = '0;
      fill_d  = '0;
      depth_d = cfg_clamped;
      tap_d   = '0;
      valid_d = '0;
    end else if (bus.shift_en) begin
      ptr_d   = (D_W'(ptr_q) == depth_q - D_W'(1)) ? '0 : ptr_q + PTR_W'(1);
      fill_d  = (fill_inc > fill_cap) ? fill_cap : fill_inc;
      valid_d = valid_hit;
      for (int k = 0; k < NUM_TAPS; k++) begin
        tap_d[k*WIDTH +: WIDTH] = valid_hit[k] ? seg_rdata[k] : '0;
      end
    end
  end

  // State registers; reset wins over everything and reloads the depth.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      fill_q  <= '0;
      depth_q <= cfg_clamped;
      tap_q   <= '0;
      valid_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      depth_q <= depth_d;
      tap_q   <= tap_d;
      valid_q <= valid_d;
    end
  end

  assign bus.tap_out   = tap_q;
  assign bus.tap_valid = valid_q;
endmodule

// File: tb/tb_ram_tap_line_buffer.sv
// Bench for ram_tap_line_buffer: fixed vector table, directed corner sequences
// and a randomized run checked against a sample-history model.
module tb_ram_tap_line_buffer;
  localparam int W  = 8;
  localparam int MD = 8;
  localparam int NT = 2;
  localparam int DW = 4;

  logic clock;
  logic reset;

  ram_tap_line_buffer_if #(.WIDTH(W), .NUM_TAPS(NT), .D_W(DW)) bus ();

  ram_tap_line_buffer #(.WIDTH(W), .MAX_DEPTH(MD), .NUM_TAPS(NT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: every sample accepted since the last reset/flush.
  int hist[$];
  int mdepth = 1;

  typedef struct {
    bit r; bit f; int cfg; bit en; int din;
    int t0; int t1; int v;
  } vec_t;
  vec_t tbl[16];

  function automatic int ref_clamp(input int c);
    if (c == 0) return 1;
    if (c > MD) return MD;
    return c;
  endfunction

  task automatic check_eq(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, then advance the model.
  task automatic step(input bit r, input bit f, input int cfg, input bit en, input int din);
    logic [DW-1:0] c4;
    logic [W-1:0]  d8;
    c4 = DW'(cfg);
    d8 = W'(din);
    reset        = r;
    bus.flush    = f;
    bus.cfg_depth = c4;
    bus.shift_en = en;
    bus.shift_in = d8;
    @(posedge clock);
    #1;
    if (r || f) begin
      hist.delete();
      mdepth = ref_clamp(int'(c4));
    end else if (en) begin
      hist.push_back(int'(d8));
    end
  endtask

  function automatic int exp_tap(input int k);
    int lag = (k + 1) * mdepth;
    if (hist.size() > lag) return hist[hist.size() - 1 - lag];
    return 0;
  endfunction

  function automatic int exp_valid(input int k);
    return (hist.size() > (k + 1) * mdepth) ? 1 : 0;
  endfunction

  task automatic model_check(input string tag);
    for (int k = 0; k < NT; k++) begin
      check_eq($sformatf("%s tap%0d", tag, k), int'(bus.tap_out[k*W +: W]), exp_tap(k));
      check_eq($sformatf("%s valid%0d", tag, k), int'(bus.tap_valid[k]), exp_valid(k));
    end
  endtask

  initial begin
    int first;
    int s0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.cfg_depth = '0;
    bus.shift_en = 1'b0;
    bus.shift_in = '0;

    // Depth 3 stream, a stall, then flush-with-shift into depth 1.
    tbl[0]  = '{1, 0, 3, 0, 0,     0,    0,    0};
    tbl[1]  = '{0, 0, 3, 1, 0,     0,    0,    0};
    tbl[2]  = '{0, 0, 3, 1, 1,     0,    0,    0};
    tbl[3]  = '{0, 0, 3, 1, 2,     0,    0,    0};
    tbl[4]  = '{0, 0, 3, 1, 3,     0,    0,    1};
    tbl[5]  = '{0, 0, 3, 1, 4,     1,    0,    1};
    tbl[6]  = '{0, 0, 3, 1, 5,     2,    0,    1};
    tbl[7]  = '{0, 0, 3, 1, 6,     3,    0,    3};
    tbl[8]  = '{0, 0, 3, 1, 7,     4,    1,    3};
    tbl[9]  = '{0, 0, 3, 0, 8'h55, 4,    1,    3};
    tbl[10] = '{0, 0, 3, 1, 8,     5,    2,    3};
    tbl[11] = '{0, 1, 1, 1, 8'hAA, 0,    0,    0};
    tbl[12] = '{0, 0, 1, 1, 8'h10, 0,    0,    0};
    tbl[13] = '{0, 0, 1, 1, 8'h11, 8'h10, 0,   1};
    tbl[14] = '{0, 0, 1, 1, 8'h12, 8'h11, 8'h10, 3};
    tbl[15] = '{0, 0, 1, 1, 8'h13, 8'h12, 8'h11, 3};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].cfg, tbl[i].en, tbl[i].din);
      check_eq($sformatf("vec%0d tap0", i), int'(bus.tap_out[7:0]), tbl[i].t0);
      check_eq($sformatf("vec%0d tap1", i), int'(bus.tap_out[15:8]), tbl[i].t1);
      check_eq($sformatf("vec%0d valid", i), int'(bus.tap_valid), tbl[i].v);
      $display("[TB] vec %0d en=%0d din=%02h -> taps=%04h valid=%0b", i, tbl[i].en,
               tbl[i].din, bus.tap_out, bus.tap_valid);
    end

    // Clamp low: depth 0 behaves as 1, tap0 lags one shift.
    step(1, 0, 0, 0, 0);
    model_check("clamp0 reset");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, $urandom_range(255));
      model_check("clamp0");
    end
    check_eq("clamp0 lag1", int'(bus.tap_out[7:0]), hist[hist.size() - 2]);

    // Clamp high: depth 12 behaves as 8; pointer wraps several times.
    step(1, 0, 12, 0, 0);
    first = -1;
    for (int i = 0; i < 26; i++) begin
      step(0, 0, 12, 1, 8'h20 + i);
      model_check("clamp12");
      if (i == 8) first = int'(bus.tap_out[7:0]);
    end
    check_eq("clamp12 lag8", first, 8'h20);

    // Flush + reconfigure after s_10: depth 3 -> 5.
    step(1, 0, 3, 0, 0);
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 3, 1, i);
      model_check("pre-flush");
    end
    step(0, 1, 5, 0, 0);
    model_check("flush");
    check_eq("flush valid", int'(bus.tap_valid), 0);
    s0 = 8'h40;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 5, 1, s0 + i);
      model_check("post-flush");
    end
    check_eq("post-flush first", int'(bus.tap_out[7:0]), s0);
    check_eq("post-flush valid0", int'(bus.tap_valid[0]), 1);

    // Reset mid-stream at s_7 with shift_en high, then replay the basic stream.
    step(1, 0, 3, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 3, 1, i);
    step(1, 0, 3, 1, 7);
    check_eq("midreset taps", int'(bus.tap_out), 0);
    check_eq("midreset valid", int'(bus.tap_valid), 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 3, tbl[i].en, tbl[i].din);
      check_eq($sformatf("replay%0d tap0", i), int'(bus.tap_out[7:0]), tbl[i].t0);
      check_eq($sformatf("replay%0d tap1", i), int'(bus.tap_out[15:8]), tbl[i].t1);
      check_eq($sformatf("replay%0d valid", i), int'(bus.tap_valid), tbl[i].v);
    end

    // Randomized traffic against the history model.
    step(1, 0, 3, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit f;
      bit en;
      r  = ($urandom_range(299) == 0);
      f  = ($urandom_range(79) == 0);
      en = ($urandom_range(9) < 7);
      step(r, f, $urandom_range(15), en, $urandom_range(255));
      model_check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
